// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive peripheral: register map, STATUS
// bit layout and the receive state machine encoding.
package uart_pkg;

    localparam logic STATUS_ADDR = 1'b0;
    localparam logic DATA_ADDR   = 1'b1;

    localparam int unsigned ST_NOT_EMPTY_BIT = 0;
    localparam int unsigned ST_OVERRUN_BIT   = 1;
    localparam int unsigned ST_FRAMING_BIT   = 2;
    localparam int unsigned ST_COUNT_LSB     = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/uart_receiver.sv
// 8N1 deframer: synchronises the rx pin, finds mid-bit sample points with a
// down-counter and emits one-cycle byte / framing-error pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       framing_error_o
);

    localparam int unsigned CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_BIT - 1);

    logic            rx_meta_q;
    logic            rx_sync_q;
    rx_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            bit_tick;

    assign bit_tick = (cnt_q == '0);

    // Pulses are decoded from the stop-bit sample point itself so the FIFO
    // write lands on the same edge the stop bit is sampled.
    assign valid_o         = (state_q == STOP) && bit_tick && rx_sync_q;
    assign framing_error_o = (state_q == STOP) && bit_tick && !rx_sync_q;
    assign data_o          = shift_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            case (state_q)
                IDLE: begin
                    if (!rx_sync_q) begin
                        cnt_q   <= HALF_LOAD;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        if (rx_sync_q) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q     <= FULL_LOAD;
                            bit_idx_q <= '0;
                            state_q   <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        cnt_q     <= FULL_LOAD;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        state_q <= rx_sync_q ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not look like a new start bit.
                    if (rx_sync_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_receiver_interface.sv
// Bus-facing UART receive peripheral: receive FIFO, sticky error flags and
// the STATUS / DATA register interface around the uart_receiver deframer.
module uart_receiver_interface
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT  = 868,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enable,
    input  logic        write_req,
    input  logic        read_req,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    input  logic        rx
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PW    = FIFO_DEPTH_LOG2 + 1;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ferr;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          overrun_q;
    logic          overrun_d;
    logic          framing_q;
    logic          framing_d;
    logic [31:0]   read_data_q;
    logic [31:0]   read_data_d;
    logic          read_valid_q;

    logic [PW-1:0] count;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          status_wr;
    logic [31:0]   status_word;
    logic          unused_bus;

    uart_receiver #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_rx (
        .clk_i           (clk),
        .rst_ni          (reset_n),
        .rx_i            (rx),
        .data_o          (rx_data),
        .valid_o         (rx_valid),
        .framing_error_o (rx_ferr)
    );

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

    assign pop       = read_req && (addr == DATA_ADDR) && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
    assign push      = rx_valid && (!full || pop);
    assign status_wr = write_req && (addr == STATUS_ADDR) && byte_enable[0];

    assign unused_bus = ^{write_data[31:3], write_data[0], byte_enable[3:1]};

    always_comb begin
        overrun_d = overrun_q;
        if (status_wr && write_data[ST_OVERRUN_BIT]) begin
            overrun_d = 1'b0;
        end
        if (rx_valid && full && !pop) begin
            overrun_d = 1'b1;
        end

        framing_d = framing_q;
        if (status_wr && write_data[ST_FRAMING_BIT]) begin
            framing_d = 1'b0;
        end
        if (rx_ferr) begin
            framing_d = 1'b1;
        end
    end

    always_comb begin
        status_word                          = '0;
        status_word[ST_NOT_EMPTY_BIT]        = !empty;
        status_word[ST_OVERRUN_BIT]          = overrun_q;
        status_word[ST_FRAMING_BIT]          = framing_q;
        status_word[ST_COUNT_LSB +: PW]      = count;

        read_data_d = read_data_q;
        if (read_req) begin
            if (addr == STATUS_ADDR) begin
                read_data_d = status_word;
            end else if (empty) begin
                read_data_d = '0;
            end else begin
                read_data_d = {24'b0, mem_q[rd_ptr_q[PW-2:0]]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overrun_q    <= 1'b0;
            framing_q    <= 1'b0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[PW-2:0]] <= rx_data;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            overrun_q    <= overrun_d;
            framing_q    <= framing_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_req;
        end
    end

    assign read_data       = read_data_q;
    assign read_data_valid = read_valid_q;

endmodule

// File: tb/tb_uart_receiver_interface.sv
// Self-checking bench for uart_receiver_interface: directed scenarios plus a
// randomized sequence compared against a queue-based model of the peripheral.
module tb_uart_receiver_interface;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        addr;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        write_req;
    logic        read_req;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        rx;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q[$];
    logic       m_ovr;
    logic       m_ferr;

    uart_receiver_interface #(
        .CLOCKS_PER_BIT (CPB),
        .FIFO_DEPTH_LOG2(3)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .addr           (addr),
        .write_data     (write_data),
        .byte_enable    (byte_enable),
        .write_req      (write_req),
        .read_req       (read_req),
        .read_data      (read_data),
        .read_data_valid(read_data_valid),
        .rx             (rx)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (m_q.size() != 0);
        s[1]    = m_ovr;
        s[2]    = m_ferr;
        s[11:8] = 4'(m_q.size());
        return s;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (m_q.size() < 8) m_q.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    function automatic logic [31:0] model_pop();
        logic [7:0] b;
        if (m_q.size() == 0) return 32'h0;
        b = m_q.pop_front();
        return {24'h0, b};
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one 10-bit frame, one clock per loop pass. Optionally issues a
    // DATA read on cycle pop_at and stops early at cycle cut_at.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int pop_at, input int cut_at,
                              output logic [31:0] pd, output logic pv);
        int bitn;
        pd = '0;
        pv = 1'b0;
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            if (i == cut_at) return;
            if (pop_at >= 0 && i == pop_at + 1) begin
                pd = read_data;
                pv = read_data_valid;
            end
            read_req = (i == pop_at);
            addr     = 1'b1;
            bitn     = i / CPB;
            if (bitn == 0)      rx = 1'b0;
            else if (bitn == 9) rx = stop_bit;
            else                rx = b[bitn-1];
        end
        read_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [31:0] d;
        logic        v;
        send_frame(b, 1'b1, -1, -1, d, v);
        idle(2);
    endtask

    task automatic bus_read(input logic a, output logic [31:0] d, output logic v);
        @(negedge clk);
        addr     = a;
        read_req = 1'b1;
        @(negedge clk);
        read_req = 1'b0;
        d = read_data;
        v = read_data_valid;
    endtask

    task automatic bus_write(input logic a, input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        addr        = a;
        write_data  = wd;
        byte_enable = be;
        write_req   = 1'b1;
        @(negedge clk);
        write_req = 1'b0;
        if (a == 1'b0 && be[0]) begin
            if (wd[1]) m_ovr = 1'b0;
            if (wd[2]) m_ferr = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        reset_n = 1'b0; rx = 1'b1; addr = 1'b0; write_data = '0;
        byte_enable = '0; write_req = 1'b0; read_req = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (read_data !== 32'h0 || read_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h valid=%b expected 0/0", read_data, read_data_valid);
        end
        reset_n = 1'b1;
        idle(4);
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got %h valid=%b expected 00000000 valid=1", d, v);
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        logic        v;
        send_byte(8'hA5);
        model_push(8'hA5);
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h101 || d !== exp_status()) begin
            errors++;
            $display("FAIL single_status_before: got %h expected %h", d, 32'h101);
        end
        bus_read(1'b1, d, v);
        checks++;
        if (d !== model_pop() || v !== 1'b1) begin
            errors++;
            $display("FAIL single_data: got %h valid=%b expected 000000a5 valid=1", d, v);
        end
        @(negedge clk);
        checks++;
        if (read_data_valid !== 1'b0 || read_data !== 32'hA5) begin
            errors++;
            $display("FAIL single_hold: got data=%h valid=%b expected 000000a5/0", read_data, read_data_valid);
        end
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL single_status_after: got %h expected 00000000", d);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic [31:0] e;
        logic        v;
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(i));
            model_push(8'(i));
        end
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h803 || d !== exp_status()) begin
            errors++;
            $display("FAIL overrun_status: got %h expected 00000803", d);
        end
        for (int i = 1; i <= 9; i++) begin
            e = model_pop();
            bus_read(1'b1, d, v);
            checks++;
            if (d !== e || v !== 1'b1) begin
                errors++;
                $display("FAIL overrun_read%0d: got %h valid=%b expected %h valid=1", i, d, v, e);
            end
        end
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h002 || d !== exp_status()) begin
            errors++;
            $display("FAIL overrun_empty_status: got %h expected 00000002", d);
        end
    endtask

    task automatic test_clear();
        logic [31:0] d;
        logic        v;
        bus_write(1'b0, 32'h6, 4'h0);
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h002 || d !== exp_status()) begin
            errors++;
            $display("FAIL clear_be0: got %h expected 00000002", d);
        end
        bus_write(1'b1, 32'h6, 4'hF);
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h002) begin
            errors++;
            $display("FAIL clear_data_addr: got %h expected 00000002", d);
        end
        // Read and clearing write in the same cycle: read sees pre-write flags.
        @(negedge clk);
        addr = 1'b0; write_data = 32'h6; byte_enable = 4'h1;
        write_req = 1'b1; read_req = 1'b1;
        @(negedge clk);
        write_req = 1'b0; read_req = 1'b0;
        m_ovr = 1'b0;
        checks++;
        if (read_data !== 32'h002 || read_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_same_cycle_read: got %h valid=%b expected 00000002 valid=1", read_data, read_data_valid);
        end
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h0 || d !== exp_status()) begin
            errors++;
            $display("FAIL clear_after: got %h expected 00000000", d);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic        v;
        @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        idle(40);
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h0 || d !== exp_status()) begin
            errors++;
            $display("FAIL glitch_status: got %h expected 00000000", d);
        end
    endtask

    task automatic test_framing();
        logic [31:0] d;
        logic        v;
        send_frame(8'h3C, 1'b0, -1, -1, d, v);
        m_ferr = 1'b1;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(4);
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h004 || d !== exp_status()) begin
            errors++;
            $display("FAIL framing_status: got %h expected 00000004", d);
        end
        send_byte(8'h55);
        model_push(8'h55);
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h105 || d !== exp_status()) begin
            errors++;
            $display("FAIL framing_recover_status: got %h expected 00000105", d);
        end
        bus_read(1'b1, d, v);
        checks++;
        if (d !== model_pop()) begin
            errors++;
            $display("FAIL framing_recover_data: got %h expected 00000055", d);
        end
        bus_write(1'b0, 32'h4, 4'h1);
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h0 || d !== exp_status()) begin
            errors++;
            $display("FAIL framing_clear: got %h expected 00000000", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        v;
        send_frame(8'h77, 1'b1, -1, 5 * CPB + 3, d, v);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (read_data !== 32'h0 || read_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got data=%h valid=%b expected 0/0", read_data, read_data_valid);
        end
        reset_n = 1'b1;
        model_reset();
        idle(4);
        send_byte(8'h12);
        model_push(8'h12);
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h101 || d !== exp_status()) begin
            errors++;
            $display("FAIL reset_mid_status: got %h expected 00000101", d);
        end
        bus_read(1'b1, d, v);
        checks++;
        if (d !== model_pop()) begin
            errors++;
            $display("FAIL reset_mid_data: got %h expected 00000012", d);
        end
    endtask

    task automatic test_full_pushpop();
        logic [31:0] d;
        logic [31:0] e;
        logic        v;
        logic [7:0]  b;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            send_byte(b);
            model_push(b);
        end
        // Stop bit of the 9th byte is sampled on the edge 155 clocks after the
        // start bit is driven; the DATA read is aimed at that same edge.
        b = 8'($urandom);
        e = model_pop();
        model_push(b);
        send_frame(b, 1'b1, 10 * CPB - 6, -1, d, v);
        idle(2);
        checks++;
        if (d !== e || v !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_read: got %h valid=%b expected %h valid=1", d, v, e);
        end
        bus_read(1'b0, d, v);
        checks++;
        if (d !== 32'h801 || d !== exp_status()) begin
            errors++;
            $display("FAIL pushpop_status: got %h expected 00000801", d);
        end
        for (int i = 0; i < 8; i++) begin
            e = model_pop();
            bus_read(1'b1, d, v);
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL pushpop_drain%0d: got %h expected %h", i, d, e);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] e;
        logic        v;
        logic [7:0]  b;
        logic [31:0] wd;
        logic [3:0]  be;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0, 1: begin
                    b = 8'($urandom);
                    if ($urandom_range(0, 5) == 0) begin
                        send_frame(b, 1'b0, -1, -1, d, v);
                        m_ferr = 1'b1;
                    end else begin
                        send_frame(b, 1'b1, -1, -1, d, v);
                        model_push(b);
                    end
                    idle(2);
                end
                2: begin
                    e = model_pop();
                    bus_read(1'b1, d, v);
                    checks++;
                    if (d !== e || v !== 1'b1) begin
                        errors++;
                        $display("FAIL random_data it=%0d: got %h valid=%b expected %h valid=1", it, d, v, e);
                    end
                end
                3: begin
                    e = exp_status();
                    bus_read(1'b0, d, v);
                    checks++;
                    if (d !== e) begin
                        errors++;
                        $display("FAIL random_status it=%0d: got %h expected %h", it, d, e);
                    end
                end
                default: begin
                    wd = $urandom & 32'h6;
                    be = 4'($urandom);
                    bus_write(1'b0, wd, be);
                end
            endcase
        end
        e = exp_status();
        bus_read(1'b0, d, v);
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL random_final_status: got %h expected %h", d, e);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_clear();
        test_glitch();
        test_framing();
        test_reset_mid();
        test_full_pushpop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
